// File: rtl/heater_enable_sequencer.sv
// Staggered heater turn-on sequencer with per-channel error latching, timed
// error-clear pulses and a global trip after too many error events.
module heater_enable_sequencer #(
  parameter int N              = 32,
  parameter int STAGGER_CYCLES = 2000,
  parameter int CLR_PULSE      = 4,
  parameter int TRIP_LIMIT     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_enable,
  input  logic [N-1:0]           err_clear_req,
  input  logic                   trip_clear,
  input  logic [N-1:0]           heater_error,
  output logic [N-1:0]           heater_enable,
  output logic [N-1:0]           heater_err_clear,
  output logic [N-1:0]           error_latched,
  output logic                   trip,
  output logic [$clog2(N+1)-1:0] active_count
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam int STG_W = $clog2(STAGGER_CYCLES + 1);
  localparam int CLR_W = $clog2(CLR_PULSE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TRIPPED} state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  logic [N-1:0]       req_meta_reg, req_s_reg;
  logic [N-1:0]       clr_meta_reg, clr_s_reg, clr_d_reg;
  logic               tclr_meta_reg, tclr_s_reg, tclr_d_reg;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next, ptr_inc;
  logic [STG_W-1:0]   stg_cnt_reg, stg_cnt_next;
  logic [7:0]         trip_count_reg, trip_count_next;
  logic               trip_reg, trip_next;
  logic [N-1:0]       enable_reg, enable_next;
  logic [N-1:0]       latched_reg, latched_next;
  logic [CNT_W-1:0]   active_count_reg, active_count_next;
  logic [N-1:0]       clr_edge, pulse_end, grant, rise;
  logic               tclr_edge, trip_hit, eligible;
  logic [31:0]        trip_sum;

  // Software-side requests arrive from another clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_reg  <= '0;
      req_s_reg     <= '0;
      clr_meta_reg  <= '0;
      clr_s_reg     <= '0;
      clr_d_reg     <= '0;
      tclr_meta_reg <= 1'b0;
      tclr_s_reg    <= 1'b0;
      tclr_d_reg    <= 1'b0;
    end else begin
      req_meta_reg  <= req_enable;
      req_s_reg     <= req_meta_reg;
      clr_meta_reg  <= err_clear_req;
      clr_s_reg     <= clr_meta_reg;
      clr_d_reg     <= clr_s_reg;
      tclr_meta_reg <= trip_clear;
      tclr_s_reg    <= tclr_meta_reg;
      tclr_d_reg    <= tclr_s_reg;
    end
  end

  assign clr_edge  = clr_s_reg & ~clr_d_reg;
  assign tclr_edge = tclr_s_reg & ~tclr_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      logic [CLR_W-1:0] clr_cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                clr_cnt_reg <= '0;
        else if (clr_edge[gi])     clr_cnt_reg <= CLR_W'(CLR_PULSE);
        else if (clr_cnt_reg != 0) clr_cnt_reg <= clr_cnt_reg - CLR_W'(1);
      end

      assign heater_err_clear[gi] = (clr_cnt_reg != '0);
      assign pulse_end[gi]        = (clr_cnt_reg == CLR_W'(1));
      // An active error both sets the latch and blocks the clear.
      assign latched_next[gi]     = heater_error[gi] | (latched_reg[gi] & ~pulse_end[gi]);
    end
  endgenerate

  assign rise     = latched_next & ~latched_reg;
  assign trip_hit = (trip_count_reg == 8'(TRIP_LIMIT));
  assign eligible = req_s_reg[ptr_reg] & ~enable_reg[ptr_reg] & ~latched_reg[ptr_reg];
  assign ptr_inc  = (ptr_reg == PTR_W'(N - 1)) ? '0 : ptr_reg + PTR_W'(1);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    stg_cnt_next = stg_cnt_reg;
    grant        = '0;
    case (state_reg)
      ST_IDLE: begin
        if (trip_hit) begin
          state_next = ST_TRIPPED;
        end else if (eligible) begin
          grant[ptr_reg] = 1'b1;
          stg_cnt_next   = STG_W'(STAGGER_CYCLES - 1);
          state_next     = ST_WAIT;
        end else begin
          ptr_next = ptr_inc;
        end
      end
      ST_WAIT: begin
        if (trip_hit) begin
          state_next = ST_TRIPPED;
        end else if (stg_cnt_reg == '0) begin
          ptr_next   = ptr_inc;
          state_next = ST_IDLE;
        end else begin
          stg_cnt_next = stg_cnt_reg - STG_W'(1);
        end
      end
      ST_TRIPPED: begin
        if (tclr_edge) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // trip_clear wipes the history; errors landing the same cycle still count.
    trip_sum        = 32'(tclr_edge ? 8'd0 : trip_count_reg) + 32'(popcount(rise));
    trip_count_next = (trip_sum >= 32'(TRIP_LIMIT)) ? 8'(TRIP_LIMIT) : trip_sum[7:0];

    // Error beats a same-cycle grant; the FSM still takes its WAIT slot.
    enable_next = (enable_reg | grant) & req_s_reg & ~heater_error;
    if (state_next == ST_TRIPPED) enable_next = '0;
    trip_next         = (state_next == ST_TRIPPED);
    active_count_next = popcount(enable_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      ptr_reg          <= '0;
      stg_cnt_reg      <= '0;
      trip_count_reg   <= '0;
      trip_reg         <= 1'b0;
      enable_reg       <= '0;
      latched_reg      <= '0;
      active_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      ptr_reg          <= ptr_next;
      stg_cnt_reg      <= stg_cnt_next;
      trip_count_reg   <= trip_count_next;
      trip_reg         <= trip_next;
      enable_reg       <= enable_next;
      latched_reg      <= latched_next;
      active_count_reg <= active_count_next;
    end
  end

  assign heater_enable = enable_reg;
  assign error_latched = latched_reg;
  assign trip          = trip_reg;
  assign active_count  = active_count_reg;

endmodule

// File: tb/tb_heater_enable_sequencer.sv
// Directed, table-driven bench for heater_enable_sequencer (STAGGER_CYCLES=10).
// Each record is checked right after its absolute clock edge, then its inputs are applied.
module tb_heater_enable_sequencer;
  localparam int N  = 32;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_enable = '0;
  logic [N-1:0]  err_clear_req = '0;
  logic          trip_clear = 1'b0;
  logic [N-1:0]  heater_error = '0;
  logic [N-1:0]  heater_enable;
  logic [N-1:0]  heater_err_clear;
  logic [N-1:0]  error_latched;
  logic          trip;
  logic [CW-1:0] active_count;

  heater_enable_sequencer #(
    .N(N), .STAGGER_CYCLES(10), .CLR_PULSE(4), .TRIP_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_enable(req_enable), .err_clear_req(err_clear_req),
    .trip_clear(trip_clear), .heater_error(heater_error),
    .heater_enable(heater_enable), .heater_err_clear(heater_err_clear),
    .error_latched(error_latched), .trip(trip), .active_count(active_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            at;
    logic [N-1:0]  en, lat, ec;
    logic          tr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  req, err, clr;
    logic          tc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic add(input int at, input logic [N-1:0] en, input logic [N-1:0] lat,
                     input logic [N-1:0] ec, input logic tr, input int cnt,
                     input logic [N-1:0] req, input logic [N-1:0] err,
                     input logic [N-1:0] clr, input logic tc);
    vec_t v;
    v.at = at; v.en = en; v.lat = lat; v.ec = ec; v.tr = tr; v.cnt = CW'(cnt);
    v.req = req; v.err = err; v.clr = clr; v.tc = tc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at_edge=%0d got=%h expected=%h", name, tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //   at   enable        latched      err_clr  trip cnt  req           err    clr   tclr
    add( 30, 32'h0,        32'h0,       32'h0,   0, 0, 32'hF,        32'h0,   32'h0, 0);
    add( 32, 32'h0,        32'h0,       32'h0,   0, 0, 32'hF,        32'h0,   32'h0, 0);
    add( 33, 32'h1,        32'h0,       32'h0,   0, 0, 32'hF,        32'h0,   32'h0, 0);
    add( 34, 32'h1,        32'h0,       32'h0,   0, 1, 32'hF,        32'h0,   32'h0, 0);
    add( 43, 32'h1,        32'h0,       32'h0,   0, 1, 32'hF,        32'h0,   32'h0, 0);
    add( 44, 32'h3,        32'h0,       32'h0,   0, 1, 32'hF,        32'h0,   32'h0, 0);
    add( 55, 32'h7,        32'h0,       32'h0,   0, 2, 32'hF,        32'h0,   32'h0, 0);
    add( 66, 32'hF,        32'h0,       32'h0,   0, 3, 32'hF,        32'h0,   32'h0, 0);
    add( 67, 32'hF,        32'h0,       32'h0,   0, 4, 32'hF,        32'h0,   32'h0, 0);
    add( 80, 32'hF,        32'h0,       32'h0,   0, 4, 32'hF,        32'h4,   32'h0, 0);
    add( 81, 32'hB,        32'h4,       32'h0,   0, 4, 32'hF,        32'h0,   32'h0, 0);
    add( 82, 32'hB,        32'h4,       32'h0,   0, 3, 32'hF,        32'h0,   32'h0, 0);
    add( 90, 32'hB,        32'h4,       32'h0,   0, 3, 32'hF,        32'h0,   32'h4, 0);
    add( 92, 32'hB,        32'h4,       32'h0,   0, 3, 32'hF,        32'h0,   32'h4, 0);
    add( 93, 32'hB,        32'h4,       32'h4,   0, 3, 32'hF,        32'h0,   32'h4, 0);
    add( 96, 32'hB,        32'h4,       32'h4,   0, 3, 32'hF,        32'h0,   32'h4, 0);
    add( 97, 32'hB,        32'h0,       32'h0,   0, 3, 32'hF,        32'h0,   32'h4, 0);
    add(100, 32'hB,        32'h0,       32'h0,   0, 3, 32'hF,        32'h0,   32'h0, 0);
    add(106, 32'hB,        32'h0,       32'h0,   0, 3, 32'hF,        32'h0,   32'h0, 0);
    add(107, 32'hF,        32'h0,       32'h0,   0, 3, 32'hF,        32'h0,   32'h0, 0);
    add(108, 32'hF,        32'h0,       32'h0,   0, 4, 32'hF,        32'h0,   32'h0, 0);
    add(120, 32'hF,        32'h0,       32'h0,   0, 4, 32'hF,        32'h4,   32'h0, 0);
    add(121, 32'hB,        32'h4,       32'h0,   0, 4, 32'hF,        32'h4,   32'h4, 0);
    add(127, 32'hB,        32'h4,       32'h4,   0, 3, 32'hF,        32'h4,   32'h4, 0);
    add(128, 32'hB,        32'h4,       32'h0,   0, 3, 32'hF,        32'h4,   32'h4, 0);
    add(130, 32'hB,        32'h4,       32'h0,   0, 3, 32'h8000001F, 32'h0,   32'h0, 0);
    add(145, 32'hB,        32'h4,       32'h0,   0, 3, 32'h8000001F, 32'h0,   32'h0, 0);
    add(146, 32'h8000000B, 32'h4,       32'h0,   0, 3, 32'h8000001F, 32'h0,   32'h0, 0);
    add(150, 32'h8000000B, 32'h4,       32'h0,   0, 4, 32'h1F,       32'h0,   32'h0, 0);
    add(152, 32'h8000000B, 32'h4,       32'h0,   0, 4, 32'h1F,       32'h0,   32'h0, 0);
    add(153, 32'hB,        32'h4,       32'h0,   0, 4, 32'h1F,       32'h0,   32'h0, 0);
    add(154, 32'hB,        32'h4,       32'h0,   0, 3, 32'h1F,       32'h0,   32'h0, 0);
    add(160, 32'hB,        32'h4,       32'h0,   0, 3, 32'h1F,       32'h0,   32'h0, 0);
    add(161, 32'h1B,       32'h4,       32'h0,   0, 3, 32'h1F,       32'h0,   32'h0, 0);
    add(162, 32'h1B,       32'h4,       32'h0,   0, 4, 32'h1F,       32'h0,   32'h0, 0);
    add(175, 32'h1B,       32'h4,       32'h0,   0, 4, 32'h1F,       32'h0,   32'h0, 1);
    add(180, 32'h1B,       32'h4,       32'h0,   0, 4, 32'h1F,       32'h0,   32'h0, 0);
    add(185, 32'h1B,       32'h4,       32'h0,   0, 4, 32'h1F,       32'h3,   32'h0, 0);
    add(186, 32'h18,       32'h7,       32'h0,   0, 4, 32'h1F,       32'h0,   32'h0, 0);
    add(190, 32'h18,       32'h7,       32'h0,   0, 2, 32'h1F,       32'h8,   32'h0, 0);
    add(191, 32'h10,       32'hF,       32'h0,   0, 2, 32'h1F,       32'h0,   32'h0, 0);
    add(192, 32'h10,       32'hF,       32'h0,   0, 1, 32'h1F,       32'h0,   32'h0, 0);
    add(195, 32'h10,       32'hF,       32'h0,   0, 1, 32'h1F,       32'h400, 32'h0, 0);
    add(196, 32'h10,       32'h40F,     32'h0,   0, 1, 32'h1F,       32'h0,   32'h0, 0);
    add(197, 32'h0,        32'h40F,     32'h0,   1, 1, 32'h1F,       32'h0,   32'h0, 0);
    add(198, 32'h0,        32'h40F,     32'h0,   1, 0, 32'h1F,       32'h0,   32'h0, 0);
    add(200, 32'h0,        32'h40F,     32'h0,   1, 0, 32'h1F,       32'h0,   32'hF, 0);
    add(203, 32'h0,        32'h40F,     32'hF,   1, 0, 32'h1F,       32'h0,   32'hF, 0);
    add(206, 32'h0,        32'h40F,     32'hF,   1, 0, 32'h1F,       32'h0,   32'hF, 0);
    add(207, 32'h0,        32'h400,     32'h0,   1, 0, 32'h1F,       32'h0,   32'hF, 0);
    add(210, 32'h0,        32'h400,     32'h0,   1, 0, 32'h1F,       32'h0,   32'hF, 1);
    add(212, 32'h0,        32'h400,     32'h0,   1, 0, 32'h1F,       32'h0,   32'hF, 1);
    add(213, 32'h0,        32'h400,     32'h0,   0, 0, 32'h1F,       32'h0,   32'hF, 1);
    add(214, 32'h1,        32'h400,     32'h0,   0, 0, 32'h1F,       32'h0,   32'hF, 1);
    add(215, 32'h1,        32'h400,     32'h0,   0, 1, 32'h1F,       32'h0,   32'h0, 0);
    add(225, 32'h3,        32'h400,     32'h0,   0, 1, 32'h1F,       32'h0,   32'h0, 0);
    add(236, 32'h7,        32'h400,     32'h0,   0, 2, 32'h1F,       32'h0,   32'h0, 0);
    add(240, 32'h7,        32'h400,     32'h0,   0, 3, 32'h1F,       32'h0,   32'h0, 0);

    // Outputs while held in reset.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enable",    0, heater_enable, 32'h0);
    chk("reset_latched",   0, error_latched, 32'h0);
    chk("reset_err_clear", 0, heater_err_clear, 32'h0);
    chk("reset_trip",      0, 32'(trip), 32'h0);
    chk("reset_count",     0, 32'(active_count), 32'h0);
    rst_n = 1'b1;
    cyc   = 0;

    for (int k = 0; k < tbl.size(); k++) begin
      while (cyc < tbl[k].at) tick();
      chk("heater_enable",    cyc, heater_enable, tbl[k].en);
      chk("error_latched",    cyc, error_latched, tbl[k].lat);
      chk("heater_err_clear", cyc, heater_err_clear, tbl[k].ec);
      chk("trip",             cyc, 32'(trip), 32'(tbl[k].tr));
      chk("active_count",     cyc, 32'(active_count), 32'(tbl[k].cnt));
      $display("vec %0d edge=%0d en=%h lat=%h clr=%h trip=%0d cnt=%0d", k, cyc,
               heater_enable, error_latched, heater_err_clear, trip, active_count);
      req_enable    = tbl[k].req;
      heater_error  = tbl[k].err;
      err_clear_req = tbl[k].clr;
      trip_clear    = tbl[k].tc;
    end

    // Mid-WAIT with three channels on and a latched error: reset acts without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_enable",    cyc, heater_enable, 32'h0);
    chk("async_reset_latched",   cyc, error_latched, 32'h0);
    chk("async_reset_err_clear", cyc, heater_err_clear, 32'h0);
    chk("async_reset_trip",      cyc, 32'(trip), 32'h0);
    chk("async_reset_count",     cyc, 32'(active_count), 32'h0);
    $display("async reset en=%h lat=%h trip=%0d cnt=%0d", heater_enable, error_latched,
             trip, active_count);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
